// File: rtl/write_rw_pkg.sv
// Shared types, register map and helpers for the RW write-back stage.
// Optional statistics counters are enabled by defining WRITE_RW_STATS_EN.
package swarm;

    typedef logic [3:0]  thread_id_t;
    typedef logic [5:0]  cq_slot_t;
    typedef logic [11:0] cache_addr_t;
    typedef logic [7:0]  reg_addr_t;

    typedef struct packed {
        logic [3:0]       ttype;
        logic [31:0]      ts;
        logic [31:0]      locale;
        logic [1:0][31:0] args;
    } task_desc_t;

    typedef struct packed {
        task_desc_t  task_desc;
        cq_slot_t    cq_slot;
        thread_id_t  thread;
        logic [31:0] object;
        cache_addr_t cache_addr;
    } rw_write_t;

    typedef struct packed {
        task_desc_t  task_desc;
        cq_slot_t    cq_slot;
        thread_id_t  thread;
        logic [31:0] old_object;
        logic [31:0] new_object;
    } rw_finish_t;

    typedef enum logic [1:0] {
        RW_STORE = 2'd0,
        RW_ADD   = 2'd1,
        RW_MIN   = 2'd2,
        RW_OR    = 2'd3
    } rw_op_t;

    localparam reg_addr_t RW_WRITE_OP          = 8'h20;
    localparam reg_addr_t RW_WRITE_STAT_WRITES = 8'h24;
    localparam reg_addr_t RW_WRITE_STAT_STALLS = 8'h28;

    localparam int LANES = 16;

    // Each 32-bit lane covers four bytes of the 64-byte line.
    function automatic logic [63:0] lane_strobe(input logic [3:0] lane);
        return 64'hF << {lane, 2'b00};
    endfunction

endpackage

// File: rtl/write_rw_if.sv
// Register bus between a host (master) and the RW write-back stage (slave).
interface reg_bus_if import swarm::*;;
    logic        wvalid;
    reg_addr_t   waddr;
    logic [31:0] wdata;
    logic        arvalid;
    reg_addr_t   araddr;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output wvalid, waddr, wdata, arvalid, araddr,
                    input  rvalid, rdata);
    modport slave  (input  wvalid, waddr, wdata, arvalid, araddr,
                    output rvalid, rdata);
endinterface

// File: rtl/write_rw_alu.sv
// Combinational object update for the RW write-back stage.
module rw_update_alu import swarm::*; (
    input  rw_op_t      op,
    input  logic [31:0] object,
    input  logic [31:0] arg,
    output logic [31:0] new_object
);

    always_comb begin
        new_object = arg;
        case (op)
            RW_STORE: new_object = arg;
            RW_ADD:   new_object = object + arg;
            RW_MIN:   new_object = (object < arg) ? object : arg;
            RW_OR:    new_object = object | arg;
            default:  new_object = arg;
        endcase
    end

endmodule

// File: rtl/write_rw.sv
// RW write-back stage: updates the object, issues a masked cache write and forwards the task.
// Define WRITE_RW_STATS_EN to add saturating write/stall counters on the register bus.
module write_rw import swarm::*; (
    input  logic        clk,
    input  logic        rstn,
    input  logic        task_in_valid,
    output logic        task_in_ready,
    input  rw_write_t   task_in,
    output logic        wvalid,
    input  logic        wready,
    output cache_addr_t waddr,
    output logic [511:0] wdata,
    output logic [63:0] wstrb,
    output thread_id_t  wid,
    output logic        task_out_valid,
    input  logic        task_out_ready,
    output rw_finish_t  task_out,
    reg_bus_if.slave    reg_bus
);

    rw_op_t      rw_op;
    logic [31:0] alu_new;
    logic        s1_valid;
    logic        w_done;
    logic        o_done;
    rw_write_t   s1_rec;
    logic [31:0] s1_new;
    logic        w_fire;
    logic        o_fire;
    logic        complete;
    logic [31:0] read_data;
    logic        unused_bits;

    rw_update_alu alu (
        .op         (rw_op),
        .object     (task_in.object),
        .arg        (task_in.task_desc.args[0]),
        .new_object (alu_new)
    );

    assign wvalid         = s1_valid & ~w_done;
    assign task_out_valid = s1_valid & ~o_done;
    assign w_fire         = wvalid & wready;
    assign o_fire         = task_out_valid & task_out_ready;
    assign complete       = s1_valid & (w_done | w_fire) & (o_done | o_fire);
    assign task_in_ready  = ~s1_valid | complete;

    // The done flags stop a channel that already fired from re-asserting for the same entry.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            w_done   <= 1'b0;
            o_done   <= 1'b0;
        end else if (task_in_ready) begin
            s1_valid <= task_in_valid;
            w_done   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            if (w_fire) w_done <= 1'b1;
            if (o_fire) o_done <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && task_in_ready && task_in_valid) begin
            s1_rec <= task_in;
            s1_new <= alu_new;
        end
    end

    assign waddr = s1_rec.cache_addr;
    assign wdata = {LANES{s1_new}};
    assign wstrb = lane_strobe(s1_rec.task_desc.locale[3:0]);
    assign wid   = s1_rec.thread;

    always_comb begin
        task_out.task_desc  = s1_rec.task_desc;
        task_out.cq_slot    = s1_rec.cq_slot;
        task_out.thread     = s1_rec.thread;
        task_out.old_object = s1_rec.object;
        task_out.new_object = s1_new;
    end

`ifdef WRITE_RW_STATS_EN
    logic [31:0] n_writes;
    logic [31:0] n_stall;

    // A register write to a counter's address clears it, taking priority over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            n_writes <= '0;
            n_stall  <= '0;
        end else begin
            if (reg_bus.wvalid && reg_bus.waddr == RW_WRITE_STAT_WRITES)
                n_writes <= '0;
            else if (w_fire && n_writes != 32'hFFFF_FFFF)
                n_writes <= n_writes + 32'd1;
            if (reg_bus.wvalid && reg_bus.waddr == RW_WRITE_STAT_STALLS)
                n_stall <= '0;
            else if (s1_valid && !complete && n_stall != 32'hFFFF_FFFF)
                n_stall <= n_stall + 32'd1;
        end
    end

    assign read_data = (reg_bus.araddr == RW_WRITE_STAT_WRITES) ? n_writes :
                       (reg_bus.araddr == RW_WRITE_STAT_STALLS) ? n_stall  : 32'd0;
    assign unused_bits = ^reg_bus.wdata[31:2];
`else
    assign read_data   = 32'd0;
    assign unused_bits = ^{reg_bus.wdata[31:2], reg_bus.araddr};
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rw_op          <= RW_STORE;
            reg_bus.rvalid <= 1'b0;
            reg_bus.rdata  <= '0;
        end else begin
            if (reg_bus.wvalid && reg_bus.waddr == RW_WRITE_OP)
                rw_op <= rw_op_t'(reg_bus.wdata[1:0]);
            reg_bus.rvalid <= reg_bus.arvalid;
            reg_bus.rdata  <= reg_bus.arvalid ? read_data : 32'd0;
        end
    end

endmodule
